// File: rtl/fwd_hazard_scoreboard.sv
// Operand forwarding and hazard unit for the RV32IM pipeline: youngest-first
// forwarding selects, load-use detection and a mul/div pending-writeback scoreboard.
module fwd_hazard_scoreboard #(
  parameter  int NUM_PORTS  = 2,
  parameter  int NUM_STAGES = 2,
  parameter  int ADDR_W     = 5,
  parameter  int MAX_MD     = 2,
  localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_PORTS*ADDR_W-1:0]   RS_ADDR,
  input  logic [NUM_STAGES*ADDR_W-1:0]  STG_ADDR,
  input  logic [NUM_STAGES-1:0]         STG_WEN,
  input  logic [NUM_STAGES-1:0]         STG_DVALID,
  input  logic                          ISSUE_VALID,
  input  logic                          ISSUE_MD,
  input  logic [ADDR_W-1:0]             ISSUE_RD,
  input  logic                          MD_DONE,
  input  logic [ADDR_W-1:0]             MD_RD,
  output logic [NUM_PORTS*SEL_W-1:0]    FWD_SEL,
  output logic                          STALL,
  output logic                          MD_BUSY,
  output logic [31:0]                   STALL_CYCLES
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(MAX_MD + 1);

  logic [NREG-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       stallCnt_q, stallCnt_d;

  logic [ADDR_W-1:0] rs;
  logic              found;
  logic              loadUse;
  logic              sbHit;
  logic              mdWaw;
  logic              mdFull;
  logic              accept;
  logic              mdInc;
  logic              mdDec;

  // Stages are scanned youngest first; the first match locks the select.
  always_comb begin
    FWD_SEL = '0;
    loadUse = 1'b0;
    sbHit   = 1'b0;
    rs      = '0;
    found   = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rs    = RS_ADDR[p*ADDR_W +: ADDR_W];
      found = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (!found && STG_WEN[i] && (STG_ADDR[i*ADDR_W +: ADDR_W] == rs) && (rs != '0)) begin
          found                     = 1'b1;
          FWD_SEL[p*SEL_W +: SEL_W] = SEL_W'(i + 1);
          if (!STG_DVALID[i]) loadUse = 1'b1;
        end
      end
      if (pend_q[rs]) sbHit = 1'b1;
    end
  end

  assign mdWaw   = ISSUE_MD && pend_q[ISSUE_RD];
  assign mdFull  = ISSUE_MD && (count_q == CNT_W'(MAX_MD)) && !MD_DONE;
  assign STALL   = ISSUE_VALID && (loadUse || sbHit || mdWaw || mdFull);
  assign accept  = ISSUE_VALID && !STALL;
  assign mdInc   = accept && ISSUE_MD;
  // A completion with nothing outstanding is a protocol error and is dropped.
  assign mdDec   = MD_DONE && (count_q != '0);
  assign MD_BUSY = (count_q != '0);
  assign STALL_CYCLES = stallCnt_q;

  // Clear is applied before set so a new issue to the same rd wins.
  always_comb begin
    pend_d = pend_q;
    if (mdDec) pend_d[MD_RD] = 1'b0;
    if (mdInc && (ISSUE_RD != '0)) pend_d[ISSUE_RD] = 1'b1;
    pend_d[0] = 1'b0;

    count_d = count_q;
    case ({mdInc, mdDec})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    stallCnt_d = stallCnt_q;
    if (STALL && (stallCnt_q != 32'hFFFF_FFFF)) stallCnt_d = stallCnt_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend_q     <= '0;
      count_q    <= '0;
      stallCnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      count_q    <= count_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  mdDoneUnderflow: assert property (@(posedge CLK) disable iff (RESET) !(MD_DONE && (count_q == '0)))
    else $error("MD_DONE with no outstanding mul/div");

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised next-generation operand forwarding and hazard unit for the RV32IM pipeline.
- Generalises EX-stage forwarding to any number of read ports and forwarding stages, with youngest-first priority.
- Never forwards x0.
- Detects load-use hazards, and tracks in-flight multi-cycle M-extension (mul/div) writebacks in a per-register scoreboard.
- Sits beside the ID/EX boundary; drives the EX operand-mux selects and the pipeline-wide STALL.

Parameters:
NUM_PORTS, 2, number of source-register read ports checked (rs1, rs2, ...)
NUM_STAGES, 2, forwarding sources; index 0 = youngest (MEM), index NUM_STAGES-1 = oldest (WB)
ADDR_W, 5, register address width
MAX_MD, 2, max outstanding mul/div operations (1..31)
SEL_W, clog2(NUM_STAGES+1), width of each forward select (derived; do not override)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
RS_ADDR  in  NUM_PORTS*ADDR_W  packed source addresses of the instruction in EX; port p at [p*ADDR_W +: ADDR_W]
STG_ADDR  in  NUM_STAGES*ADDR_W  packed destination address per forwarding stage
STG_WEN  in  NUM_STAGES  register-write enable per stage
STG_DVALID  in  NUM_STAGES  result data available for forwarding in that stage (0 for a load still in MEM)
ISSUE_VALID  in  1  instruction in EX is valid and wants to advance
ISSUE_MD  in  1  that instruction is a mul/div
ISSUE_RD  in  ADDR_W  its destination register
MD_DONE  in  1  mul/div unit completes this cycle
MD_RD  in  ADDR_W  destination register of the completing mul/div
FWD_SEL  out  NUM_PORTS*SEL_W  packed per-port select: 0 = register file, i+1 = stage i
STALL  out  1  hold ID/EX; insert bubble
MD_BUSY  out  1  at least one mul/div outstanding
STALL_CYCLES  out  32  saturating count of cycles with STALL=1

Behaviour:
Reset and latency
- RESET (asynchronous): scoreboard bits, outstanding count and STALL_CYCLES all go to 0.
- FWD_SEL, STALL and MD_BUSY are combinational from inputs and registered state. With all inputs at 0 after reset, every one of them is 0.
- RESET asserted mid-operation discards all pending entries immediately.

Forward select
- For each port p, pick the lowest stage index i with STG_WEN[i]=1, STG_ADDR[i]==RS_ADDR[p] and RS_ADDR[p]!=0.
- FWD_SEL[p] = i+1. If no stage matches, FWD_SEL[p] = 0.
- RS_ADDR[p]==0 always gives FWD_SEL[p]=0.
- Matching uses logical equality (==), not case equality.

Load-use hazard
- Asserted when the selected stage i for any port has STG_DVALID[i]=0.
- FWD_SEL still reports i+1 in that case.

Scoreboard
- PEND[1..2^ADDR_W-1]; PEND[0] is hardwired to 0.
- Hit: PEND[RS_ADDR[p]]=1 for any port p.
- A hit takes precedence over any stage match for stall purposes.

STALL
- STALL = ISSUE_VALID && (load_use || sb_hit || md_waw || md_full)
- md_waw = ISSUE_MD && PEND[ISSUE_RD]
- md_full = ISSUE_MD && (count == MAX_MD) && !MD_DONE

Accept
- accept = ISSUE_VALID && !STALL

Sequential update (per rising edge)
- Set: on accept && ISSUE_MD && ISSUE_RD!=0, PEND[ISSUE_RD] <= 1.
- Count increment: on accept && ISSUE_MD, count increments. This applies even when rd=0, so the completion is still counted.
- Clear: on MD_DONE, PEND[MD_RD] <= 0 and count decrements.
- Same register set and cleared in one cycle: set wins. This can only arise for distinct ops on the same rd when MD_DONE clears the older op; md_waw normally blocks it.
- Simultaneous increment and decrement: count unchanged.
- MD_DONE with count==0 is a protocol error: ignored (no underflow); simulation $error.
- MD_BUSY = (count != 0).
- STALL_CYCLES increments when STALL=1, saturates at 32'hFFFFFFFF, never wraps.

Test Plan:
1. MEM/WB priority: RS_ADDR={x5,x5}, STG_ADDR={WB:x5, MEM:x5}, both WEN=1, DVALID=2'b11 -> FWD_SEL={1,1}, STALL=0. Drop MEM WEN -> FWD_SEL={2,2}.
2. x0 guard: RS_ADDR={x0,x3}, all stages write x0 with WEN=1 -> FWD_SEL={0,0}, STALL=0.
3. Load-use: MEM writes x7 with DVALID[0]=0, RS_ADDR port1=x7, ISSUE_VALID=1 -> STALL=1, FWD_SEL port1=1, STALL_CYCLES increments by 1. Next cycle with DVALID[0]=1 -> STALL=0.
4. Mul/div dependency: issue MUL to x9 (accepted). Next instruction reads x9 -> STALL=1 until the cycle after MD_DONE with MD_RD=x9. MD_BUSY goes 1 -> 0.
5. Capacity and WAW: MAX_MD=2 with two outstanding (x10, x11). Third mul/div to x12 -> STALL=1. Same cycle with MD_DONE for x10 -> accepted, count stays 2. A mul/div to x11 while pending -> STALL=1.
6. Reset mid-operation: PEND[x9]=1, count=1, STALL_CYCLES=40; assert RESET between clock edges -> all outputs 0 immediately, a read of x9 no longer stalls.
